// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage access engine: memory op codes,
// bus size codes and the transaction FSM states.
package mem_access_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_SW);
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store strobes/replication, load lane extract
// with sign/zero extension, and the alignment check.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_db,
    input  logic [31:0] i_rdata,
    output logic        o_is_mem,
    output logic        o_is_store,
    output logic        o_misalign,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    assign o_is_mem   = is_mem_op(i_op);
    assign o_is_store = (i_op == MEM_SB) || (i_op == MEM_SH) || (i_op == MEM_SW);

    always_comb begin
        o_size     = SIZE_WORD;
        o_wstrb    = 4'b0000;
        o_wdata    = i_db;
        o_load     = i_rdata;
        o_misalign = 1'b0;
        case (i_op)
            MEM_LB: begin
                o_size = SIZE_BYTE;
                o_load = {{24{w_byte[7]}}, w_byte};
            end
            MEM_LBU: begin
                o_size = SIZE_BYTE;
                o_load = {24'd0, w_byte};
            end
            MEM_LH: begin
                o_size     = SIZE_HALF;
                o_misalign = i_addr_lo[0];
                o_load     = {{16{w_half[15]}}, w_half};
            end
            MEM_LHU: begin
                o_size     = SIZE_HALF;
                o_misalign = i_addr_lo[0];
                o_load     = {16'd0, w_half};
            end
            MEM_LW: begin
                o_misalign = |i_addr_lo;
            end
            MEM_SB: begin
                o_size  = SIZE_BYTE;
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_db[7:0]}};
            end
            MEM_SH: begin
                o_size     = SIZE_HALF;
                o_misalign = i_addr_lo[0];
                o_wstrb    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_db[15:0]}};
            end
            MEM_SW: begin
                o_misalign = |i_addr_lo;
                o_wstrb    = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage engine: runs one load/store per instruction on the data bus,
// stalls the pipeline while it is outstanding, and forwards write-back fields.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_write_mem,
    input  logic              i_mem_to_regfile,
    input  logic              i_write_regfile,
    input  logic [ADDR_W-1:0] i_da,
    input  logic [DATA_W-1:0] i_db,
    input  logic [4:0]        i_rn,
    input  logic [7:0]        i_mem_control,
    input  logic [DATA_W-1:0] i_hi,
    input  logic [DATA_W-1:0] i_lo,
    input  logic              i_write_hilo,
    input  logic              i_advance,
    output logic              o_stallreq,
    output logic              o_addr_err,
    output logic [ADDR_W-1:0] o_badvaddr,
    output logic              o_write_regfile,
    output logic [4:0]        o_rn,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_write_hilo,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_e            r_state;
    state_e            w_next;
    logic [DATA_W-1:0] r_rdata_q;
    logic              w_capture;
    logic [3:0]        w_op;
    logic              w_is_mem;
    logic              w_is_store;
    logic              w_misalign;
    logic              w_go;
    logic [DATA_W-1:0] w_load;
    // The store/load direction is fully implied by the op code.
    logic              w_unused;

    assign w_unused = i_write_mem;
    assign w_op     = (i_mem_control[7:4] == 4'd0) ? i_mem_control[3:0] : MEM_NONE;

    mem_align u_align (
        .i_op       (w_op),
        .i_addr_lo  (i_da[1:0]),
        .i_db       (i_db),
        .i_rdata    (r_rdata_q),
        .o_is_mem   (w_is_mem),
        .o_is_store (w_is_store),
        .o_misalign (w_misalign),
        .o_size     (data_size),
        .o_wstrb    (data_wstrb),
        .o_wdata    (data_wdata),
        .o_load     (w_load)
    );

    assign w_go       = w_is_mem & ~w_misalign;
    assign o_addr_err = w_is_mem & w_misalign;
    assign o_badvaddr = i_da;
    assign data_addr  = i_da;
    assign data_wr    = w_is_store;

    assign o_write_regfile = i_write_regfile & ~o_addr_err;
    assign o_rn            = i_rn;
    assign o_hi            = i_hi;
    assign o_lo            = i_lo;
    assign o_write_hilo    = i_write_hilo;
    assign o_wdata         = i_mem_to_regfile ? w_load : i_da;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) r_rdata_q <= data_rdata;
        end
    end

    // data_ok seen in REQ without addr_ok is a slave violation and is dropped.
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        data_req   = 1'b0;
        o_stallreq = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    o_stallreq = 1'b1;
                    w_next     = ST_REQ;
                end
            end
            ST_REQ: begin
                data_req   = 1'b1;
                o_stallreq = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        w_capture = 1'b1;
                        w_next    = ST_DONE;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                o_stallreq = 1'b1;
                if (data_data_ok) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_advance) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a transaction-level reference model
// checked every cycle plus hand-computed expectations per test.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_write_mem, i_mem_to_regfile, i_write_regfile;
    logic [31:0] i_da, i_db, i_hi, i_lo;
    logic [4:0]  i_rn;
    logic [7:0]  i_mem_control;
    logic        i_write_hilo, i_advance;
    logic        o_stallreq, o_addr_err, o_write_regfile, o_write_hilo;
    logic [31:0] o_badvaddr, o_wdata, o_hi, o_lo;
    logic [4:0]  o_rn;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .reset(reset),
        .i_write_mem(i_write_mem), .i_mem_to_regfile(i_mem_to_regfile),
        .i_write_regfile(i_write_regfile), .i_da(i_da), .i_db(i_db), .i_rn(i_rn),
        .i_mem_control(i_mem_control), .i_hi(i_hi), .i_lo(i_lo),
        .i_write_hilo(i_write_hilo), .i_advance(i_advance),
        .o_stallreq(o_stallreq), .o_addr_err(o_addr_err), .o_badvaddr(o_badvaddr),
        .o_write_regfile(o_write_regfile), .o_rn(o_rn), .o_wdata(o_wdata),
        .o_hi(o_hi), .o_lo(o_lo), .o_write_hilo(o_write_hilo),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit f_mem(input logic [7:0] mc);
        return (mc[7:4] == 4'd0) && (mc[3:0] >= 4'd1) && (mc[3:0] <= 4'd8);
    endfunction

    function automatic bit f_mis(input logic [7:0] mc, input logic [31:0] a);
        int op = int'(mc[3:0]);
        if (op == 3 || op == 4 || op == 7) return (a % 2) != 0;
        if (op == 5 || op == 8) return (a % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] f_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        case (op)
            1, 2: begin
                v = longint'((rd >> (8 * (a % 4))) % 256);
                if (op == 1 && v >= 128) v = v - 256;
            end
            3, 4: begin
                v = longint'((rd >> (16 * ((a / 2) % 2))) % 65536);
                if (op == 3 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] f_strb(input int op, input logic [31:0] a);
        case (op)
            6: return 4'(1 << (a % 4));
            7: return ((a % 4) >= 2) ? 4'hC : 4'h3;
            8: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] f_bwd(input int op, input logic [31:0] db);
        case (op)
            6: return (db % 256) * 32'h01010101;
            7: return (db % 65536) * 32'h00010001;
            default: return db;
        endcase
    endfunction

    function automatic logic [1:0] f_size(input int op);
        if (op == 1 || op == 2 || op == 6) return 2'd0;
        if (op == 3 || op == 4 || op == 7) return 2'd1;
        return 2'd2;
    endfunction

    bit          m_started, m_acc, m_done;
    logic [31:0] m_rdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_started <= 0; m_acc <= 0; m_done <= 0; m_rdata <= '0;
        end else if (!m_started) begin
            if (f_mem(i_mem_control) && !f_mis(i_mem_control, i_da)) m_started <= 1;
        end else if (m_done) begin
            if (i_advance) begin m_started <= 0; m_acc <= 0; m_done <= 0; end
        end else if (!m_acc) begin
            if (data_addr_ok) begin
                m_acc <= 1;
                if (data_data_ok) begin m_done <= 1; m_rdata <= data_rdata; end
            end
        end else if (data_data_ok) begin
            m_done <= 1; m_rdata <= data_rdata;
        end
    end

    always @(negedge clk) begin
        if (reset && run_cmp) begin
            int  op;
            bit  mem, mis, err, ereq, estall;
            op     = int'(i_mem_control[3:0]);
            mem    = f_mem(i_mem_control);
            mis    = f_mis(i_mem_control, i_da);
            err    = mem && mis;
            ereq   = m_started && !m_acc && !m_done;
            estall = m_started ? !m_done : (mem && !mis);
            chk("cmp stallreq", 32'(o_stallreq), 32'(estall));
            chk("cmp data_req", 32'(data_req), 32'(ereq));
            chk("cmp addr_err", 32'(o_addr_err), 32'(err));
            chk("cmp write_regfile", 32'(o_write_regfile), 32'(i_write_regfile && !err));
            chk("cmp rn", 32'(o_rn), 32'(i_rn));
            chk("cmp hi", o_hi, i_hi);
            chk("cmp lo", o_lo, i_lo);
            chk("cmp write_hilo", 32'(o_write_hilo), 32'(i_write_hilo));
            if (err) chk("cmp badvaddr", o_badvaddr, i_da);
            if (ereq) begin
                chk("cmp data_addr", data_addr, i_da);
                chk("cmp data_wr", 32'(data_wr), 32'(op >= 6));
                chk("cmp data_size", 32'(data_size), 32'(f_size(op)));
                chk("cmp data_wstrb", 32'(data_wstrb), 32'(f_strb(op, i_da)));
                if (op >= 6) chk("cmp data_wdata", data_wdata, f_bwd(op, i_db));
            end
            if (!i_mem_to_regfile) chk("cmp wdata alu", o_wdata, i_da);
            else if (m_done) chk("cmp wdata load", o_wdata, f_load(op, i_da, m_rdata));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_instr(input int op, input logic [31:0] da, input logic [31:0] db,
                             input logic [4:0] rn, input bit wr_rf, input bit m2r);
        i_mem_control    = 8'(op);
        i_write_mem      = (op >= 6 && op <= 8);
        i_mem_to_regfile = m2r;
        i_write_regfile  = wr_rf;
        i_da = da; i_db = db; i_rn = rn;
        i_hi = da ^ 32'h5A5A_0F0F; i_lo = ~db; i_write_hilo = rn[0];
    endtask

    task automatic nop();
        set_instr(0, 32'h0000_0040, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic run_txn(input string nm, input int aok_wait, input int dok_wait,
                           input logic [31:0] rd, input int adv_wait, input int exp_stalls,
                           input bit spurious, input logic [3:0] e_strb, input logic [31:0] e_bwd,
                           input logic [1:0] e_size, input bit chk_ld, input logic [31:0] e_ld);
        int stalls = 0, nreq = 0, nwait = 0, ndone = 0;
        bit acc = 0, adv = 0, fin = 0, first = 1;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (adv) fin = 1;
            else begin
                if (o_stallreq) stalls++;
                data_addr_ok = 0; data_data_ok = 0; i_advance = 0;
                if (data_req) begin
                    if (first) begin
                        chk({nm, " wstrb"}, 32'(data_wstrb), 32'(e_strb));
                        chk({nm, " size"}, 32'(data_size), 32'(e_size));
                        if (i_write_mem) chk({nm, " bus wdata"}, data_wdata, e_bwd);
                        first = 0;
                    end
                    if (nreq == aok_wait) begin
                        data_addr_ok = 1; acc = 1;
                        if (dok_wait == 0) begin data_data_ok = 1; data_rdata = rd; end
                    end else if (spurious) begin
                        data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
                    end
                    nreq++;
                end else if (acc && o_stallreq) begin
                    nwait++;
                    if (nwait == dok_wait) begin data_data_ok = 1; data_rdata = rd; end
                end else if (acc) begin
                    if (chk_ld) chk({nm, " load"}, o_wdata, e_ld);
                    if (ndone == adv_wait) begin i_advance = 1; adv = 1; end
                    ndone++;
                end
            end
        end
        data_addr_ok = 0; data_data_ok = 0; i_advance = 0;
        nop();
        chk({nm, " stalls"}, 32'(stalls), 32'(exp_stalls));
        chk({nm, " completed"}, 32'(fin), 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        nop();
        i_advance = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset data_req", 32'(data_req), 32'd0);
        chk("reset stallreq", 32'(o_stallreq), 32'd0);
        chk("reset wdata", o_wdata, 32'h0000_0040);
        @(posedge clk); #1 reset = 1; run_cmp = 1;

        @(posedge clk); #1 set_instr(8, 32'h100, 32'h1234_5678, 5'd0, 0, 0);
        run_txn("SW", 0, 1, 32'h0, 0, 3, 0, 4'hF, 32'h1234_5678, 2'd2, 0, 32'h0);
        @(negedge clk);
        chk("SW back idle stall", 32'(o_stallreq), 32'd0);
        chk("SW back idle req", 32'(data_req), 32'd0);

        @(posedge clk); #1 set_instr(6, 32'h103, 32'h0000_00AB, 5'd0, 0, 0);
        run_txn("SB", 0, 1, 32'h0, 0, 3, 0, 4'b1000, 32'hABAB_ABAB, 2'd0, 0, 32'h0);

        @(posedge clk); #1 set_instr(7, 32'h102, 32'hFFFF_1234, 5'd0, 0, 0);
        run_txn("SH", 0, 1, 32'h0, 0, 3, 0, 4'b1100, 32'h1234_1234, 2'd1, 0, 32'h0);

        @(posedge clk); #1 set_instr(1, 32'h102, 32'h0, 5'd7, 1, 1);
        run_txn("LB", 0, 1, 32'h0080_FF00, 0, 3, 0, 4'h0, 32'h0, 2'd0, 1, 32'hFFFF_FF80);

        @(posedge clk); #1 set_instr(2, 32'h102, 32'h0, 5'd8, 1, 1);
        run_txn("LBU", 0, 1, 32'h0080_FF00, 0, 3, 0, 4'h0, 32'h0, 2'd0, 1, 32'h0000_0080);

        @(posedge clk); #1 set_instr(3, 32'h102, 32'h0, 5'd9, 1, 1);
        run_txn("LH", 0, 0, 32'h8001_0000, 0, 2, 0, 4'h0, 32'h0, 2'd1, 1, 32'hFFFF_8001);

        @(posedge clk); #1 set_instr(4, 32'h100, 32'h0, 5'd10, 1, 1);
        run_txn("LHU", 0, 1, 32'h0000_9ABC, 1, 3, 0, 4'h0, 32'h0, 2'd1, 1, 32'h0000_9ABC);

        @(posedge clk); #1 set_instr(5, 32'h200, 32'h0, 5'd11, 1, 1);
        run_txn("LW", 4, 1, 32'hCAFE_F00D, 2, 7, 1, 4'h0, 32'h0, 2'd2, 1, 32'hCAFE_F00D);

        @(posedge clk); #1 set_instr(3, 32'h101, 32'h0, 5'd12, 1, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("LH mis addr_err", 32'(o_addr_err), 32'd1);
            chk("LH mis badvaddr", o_badvaddr, 32'h101);
            chk("LH mis data_req", 32'(data_req), 32'd0);
            chk("LH mis write_regfile", 32'(o_write_regfile), 32'd0);
            chk("LH mis stallreq", 32'(o_stallreq), 32'd0);
        end
        @(posedge clk); #1 set_instr(8, 32'h102, 32'h55, 5'd0, 0, 0);
        repeat (2) @(negedge clk);
        chk("SW mis addr_err", 32'(o_addr_err), 32'd1);
        chk("SW mis data_req", 32'(data_req), 32'd0);

        @(posedge clk); #1 set_instr(0, 32'hDEAD_BEEF, 32'h1, 5'd13, 1, 0);
        repeat (2) @(negedge clk);
        chk("ALU wdata", o_wdata, 32'hDEAD_BEEF);
        chk("ALU stallreq", 32'(o_stallreq), 32'd0);
        chk("ALU write_regfile", 32'(o_write_regfile), 32'd1);

        @(posedge clk); #1 set_instr(5, 32'h300, 32'h0, 5'd14, 1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("RST in REQ", 32'(data_req), 32'd1);
        data_addr_ok = 1;
        @(negedge clk);
        data_addr_ok = 0;
        chk("RST in WAIT stall", 32'(o_stallreq), 32'd1);
        chk("RST in WAIT req", 32'(data_req), 32'd0);
        #2 reset = 0;
        #1;
        chk("RST data_req", 32'(data_req), 32'd0);
        chk("RST stall follows op", 32'(o_stallreq), 32'd1);
        chk("RST rdata cleared", o_wdata, 32'h0);
        nop();
        #1;
        chk("RST idle with nop", 32'(o_stallreq), 32'd0);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("RST release req", 32'(data_req), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
